gate_bist: RTL and testbench
============================

# gate_bist

Hardware self-test engine for any 2-input combinational gate in the gate library. It is the in-silicon counterpart of the per-gate directed bench. It drives each input combination onto the gate under test, waits a programmable settle time, samples the gate output and compares it against a supplied 4-entry truth table. It stops on the first mismatch and reports the failing case number, so a gate can be exercised at board bring-up without a simulator.

## Interface
Parameters:
- SETTLE_CYCLES, default 2, cycles from driving a case to sampling its response; legal range 1..255.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- start  input  1  run request; sampled only in IDLE.
- truth  input  4  expected output; truth[{a,b}] is the expected out for inputs a,b. Sampled and held at start acceptance.
- dut_a  output  1  gate input a.
- dut_b  output  1  gate input b.
- dut_out  input  1  gate output.
- busy  output  1  high while a run is in progress.
- done  output  1  one-cycle pulse at end of run (pass or fail).
- pass  output  1  1 = all four cases matched; valid from done, held until next accepted start.
- fail_case  output  3  failing case number 1..4; 0 when pass; held like pass.

## Operation
- Case order is fixed: case 1 = (a,b)=(0,0), case 2 = (0,1), case 3 = (1,0), case 4 = (1,1). Internal index idx = {a,b} = case-1, 2 bits.
- States:
  - IDLE: dut_a=dut_b=0, busy=0. start=1 → latch truth, idx=0, drive (0,0), load settle counter with SETTLE_CYCLES-1, go to SETTLE. busy rises, pass clears to 0, fail_case clears to 0.
  - SETTLE: hold dut_a/dut_b. Counter>0 → decrement. Counter==0 → sample edge; compare dut_out with latched truth[idx].
    - Mismatch → fail_case=idx+1, pass=0, go to IDLE, done pulse.
    - Match and idx==3 → pass=1, fail_case=0, go to IDLE, done pulse.
    - Match and idx<3 → idx+1, drive the new combination, reload counter, stay in SETTLE.
- On return to IDLE, dut_a/dut_b return to 0 at the same edge.
- start while busy=1 is ignored; there is no queueing.
- truth changes during a run have no effect.
- dut_out is used directly. The gate under test is combinational within the clk domain, so no synchronizer is needed.
- Reset at any point, including mid-run: immediately busy=0, done=0, pass=0, fail_case=0, dut_a=dut_b=0, state=IDLE, idx=0. The aborted run gives no done pulse.

## Timing
- Reset values: busy 0, done 0, pass 0, fail_case 0, dut_a 0, dut_b 0.
- Edge E0 accepts start. Case k (1..4) is driven from edge E0+(k-1)·S to E0+k·S, where S=SETTLE_CYCLES. It is sampled at edge E0+k·S.
- Full pass: done is high for exactly the cycle after edge E0+4·S. busy is high for 4·S cycles.
- Fail at case k: done is high the cycle after edge E0+k·S. Later cases are never driven.
- pass and fail_case update at the same edge done rises.
- A new start may be asserted during the done cycle, since the block is in IDLE. It is accepted at the next edge. done then drops and busy rises at that edge; pass/fail_case clear.
- With S=1, each case gets one cycle of settle. The gate under test must settle within one clk period.

## Test plan
- AND gate model, truth=4'b1000, S=2: start → dut (a,b) steps 00,01,10,11 every 2 cycles; done 8 cycles after start edge; pass=1, fail_case=0.
- OR gate model, truth=4'b1000: → mismatch at (0,1); done 4 cycles after start; pass=0, fail_case=2; dut_a/dut_b back to 0; case 3 never driven.
- XOR truth 4'b0110, dut_out stuck at 0, S=3: → fail_case=2 at edge E0+6; done pulse exactly one cycle wide.
- start held high for the whole run plus one: → exactly one run while busy. A second run is accepted at the edge after done, and pass/fail_case clear at that edge.
- rst_n pulsed low during case 3 of an AND run: → all outputs 0 asynchronously, no done pulse. A fresh start after reset completes with pass=1.
- Change truth mid-run from 4'b1000 to 4'b0000 on an AND model: → still pass=1, because truth is latched at start.

Source files
------------

// File: rtl/gate_bist.sv
// Self-test engine for a 2-input combinational gate: walks the four input
// combinations, samples the gate after a settle time, and checks a truth table.
module gate_bist #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] truth,
  output logic       dut_a,
  output logic       dut_b,
  input  logic       dut_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] fail_case
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned CASE_W = 3;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [3:0]        truth_q,   truth_nxt;
  logic [IDX_W-1:0]  idx_q,     idx_nxt;
  logic [CNT_W-1:0]  cnt_q,     cnt_nxt;
  logic              dut_a_nxt, dut_b_nxt;
  logic              busy_nxt,  done_nxt, pass_nxt;
  logic [CASE_W-1:0] fail_case_nxt;

  logic              sample_c;
  logic              match_c;
  logic              last_c;
  logic [IDX_W-1:0]  idx_inc_c;

  // Sample point of the current case and its verdict against the latched table.
  assign sample_c  = (state == SETTLE) && (cnt_q == '0);
  assign match_c   = (dut_out == truth_q[idx_q]);
  assign last_c    = (idx_q == IDX_W'(3));
  assign idx_inc_c = idx_q + IDX_W'(1);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (sample_c && (!match_c || last_c)) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    truth_nxt     = truth_q;
    idx_nxt       = idx_q;
    cnt_nxt       = cnt_q;
    dut_a_nxt     = dut_a;
    dut_b_nxt     = dut_b;
    busy_nxt      = busy;
    done_nxt      = 1'b0;
    pass_nxt      = pass;
    fail_case_nxt = fail_case;
    case (state)
      IDLE: begin
        dut_a_nxt = 1'b0;
        dut_b_nxt = 1'b0;
        busy_nxt  = 1'b0;
        if (start) begin
          truth_nxt     = truth;
          idx_nxt       = '0;
          cnt_nxt       = CNT_LOAD;
          busy_nxt      = 1'b1;
          pass_nxt      = 1'b0;
          fail_case_nxt = '0;
        end
      end
      SETTLE: begin
        if (cnt_q != '0) begin
          cnt_nxt = cnt_q - CNT_W'(1);
        end else if (!match_c) begin
          fail_case_nxt = CASE_W'(idx_q) + CASE_W'(1);
          pass_nxt      = 1'b0;
          done_nxt      = 1'b1;
          busy_nxt      = 1'b0;
          dut_a_nxt     = 1'b0;
          dut_b_nxt     = 1'b0;
          idx_nxt       = '0;
        end else if (last_c) begin
          fail_case_nxt = '0;
          pass_nxt      = 1'b1;
          done_nxt      = 1'b1;
          busy_nxt      = 1'b0;
          dut_a_nxt     = 1'b0;
          dut_b_nxt     = 1'b0;
          idx_nxt       = '0;
        end else begin
          // Advance to the next combination; idx encodes {a,b}.
          idx_nxt   = idx_inc_c;
          dut_a_nxt = idx_inc_c[1];
          dut_b_nxt = idx_inc_c[0];
          cnt_nxt   = CNT_LOAD;
        end
      end
      default: begin
        dut_a_nxt = 1'b0;
        dut_b_nxt = 1'b0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      truth_q   <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      dut_a     <= 1'b0;
      dut_b     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_case <= '0;
    end else begin
      truth_q   <= truth_nxt;
      idx_q     <= idx_nxt;
      cnt_q     <= cnt_nxt;
      dut_a     <= dut_a_nxt;
      dut_b     <= dut_b_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      pass      <= pass_nxt;
      fail_case <= fail_case_nxt;
    end
  end

endmodule

// File: tb/tb_gate_bist.sv
// Directed bench for gate_bist: two instances (settle 2 and 3) driving
// behavioural gate models, checked against hand-derived timelines.
module tb_gate_bist;

  localparam logic [1:0] M_AND = 2'd0;
  localparam logic [1:0] M_OR  = 2'd1;
  localparam logic [1:0] M_XOR = 2'd2;
  localparam logic [1:0] M_ST0 = 2'd3;

  logic       clk;
  logic       rst_n;
  logic [1:0] mode;

  logic       start2, start3;
  logic [3:0] truth2, truth3;
  logic       a2, b2, out2, busy2, done2, pass2;
  logic       a3, b3, out3, busy3, done3, pass3;
  logic [2:0] fail2, fail3;

  logic [7:0] o2, o3, exp_v;
  int         checks;
  int         failures;

  function automatic logic gate(input logic [1:0] m, input logic a, input logic b);
    case (m)
      M_AND:   return a & b;
      M_OR:    return a | b;
      M_XOR:   return a ^ b;
      default: return 1'b0;
    endcase
  endfunction

  assign out2 = gate(mode, a2, b2);
  assign out3 = gate(mode, a3, b3);
  // Packed observation: {busy, done, pass, fail_case[2:0], dut_a, dut_b}.
  assign o2 = {busy2, done2, pass2, fail2, a2, b2};
  assign o3 = {busy3, done3, pass3, fail3, a3, b3};

  gate_bist #(.SETTLE_CYCLES(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .truth(truth2),
    .dut_a(a2), .dut_b(b2), .dut_out(out2),
    .busy(busy2), .done(done2), .pass(pass2), .fail_case(fail2)
  );

  gate_bist #(.SETTLE_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .truth(truth3),
    .dut_a(a3), .dut_b(b3), .dut_out(out3),
    .busy(busy3), .done(done3), .pass(pass3), .fail_case(fail3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start2 = 1'b0; start3 = 1'b0;
    truth2 = 4'b0; truth3 = 4'b0; mode = M_AND;
    #12;
    checks++;
    if (o2 !== 8'h00) begin failures++; $display("FAIL reset_dut2 got=%b exp=%b", o2, 8'h00); end
    checks++;
    if (o3 !== 8'h00) begin failures++; $display("FAIL reset_dut3 got=%b exp=%b", o3, 8'h00); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_and_pass();
    mode = M_AND; truth2 = 4'b1000; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_v = {1'b1, 1'b0, 1'b0, 3'd0, 2'(i / 2)};
      checks++;
      if (o2 !== exp_v) begin failures++; $display("FAIL and_step%0d got=%b exp=%b", i, o2, exp_v); end
      tick();
    end
    checks++;
    if (o2 !== 8'b0_1_1_000_00) begin failures++; $display("FAIL and_done got=%b exp=%b", o2, 8'b0_1_1_000_00); end
    tick();
    checks++;
    if (o2 !== 8'b0_0_1_000_00) begin failures++; $display("FAIL and_hold got=%b exp=%b", o2, 8'b0_0_1_000_00); end
  endtask

  task automatic test_or_fail();
    mode = M_OR; truth2 = 4'b1000; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_v = {1'b1, 1'b0, 1'b0, 3'd0, 2'(i / 2)};
      checks++;
      if (o2 !== exp_v) begin failures++; $display("FAIL or_step%0d got=%b exp=%b", i, o2, exp_v); end
      tick();
    end
    checks++;
    if (o2 !== 8'b0_1_0_010_00) begin failures++; $display("FAIL or_done got=%b exp=%b", o2, 8'b0_1_0_010_00); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (o2 !== 8'b0_0_0_010_00) begin failures++; $display("FAIL or_after%0d got=%b exp=%b", i, o2, 8'b0_0_0_010_00); end
    end
  endtask

  task automatic test_xor_stuck();
    mode = M_ST0; truth3 = 4'b0110; start3 = 1'b1;
    tick();
    start3 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      exp_v = {1'b1, 1'b0, 1'b0, 3'd0, 2'(i / 3)};
      checks++;
      if (o3 !== exp_v) begin failures++; $display("FAIL xor_step%0d got=%b exp=%b", i, o3, exp_v); end
      tick();
    end
    checks++;
    if (o3 !== 8'b0_1_0_010_00) begin failures++; $display("FAIL xor_done got=%b exp=%b", o3, 8'b0_1_0_010_00); end
    tick();
    checks++;
    if (o3 !== 8'b0_0_0_010_00) begin failures++; $display("FAIL xor_pulse got=%b exp=%b", o3, 8'b0_0_0_010_00); end
  endtask

  task automatic test_back_to_back();
    mode = M_AND; truth2 = 4'b1000; start2 = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      exp_v = {1'b1, 1'b0, 1'b0, 3'd0, 2'(i / 2)};
      checks++;
      if (o2 !== exp_v) begin failures++; $display("FAIL b2b_run1_%0d got=%b exp=%b", i, o2, exp_v); end
      tick();
    end
    checks++;
    if (o2 !== 8'b0_1_1_000_00) begin failures++; $display("FAIL b2b_done1 got=%b exp=%b", o2, 8'b0_1_1_000_00); end
    tick();
    checks++;
    if (o2 !== 8'b1_0_0_000_00) begin failures++; $display("FAIL b2b_restart got=%b exp=%b", o2, 8'b1_0_0_000_00); end
    start2 = 1'b0;
    for (int i = 1; i < 8; i++) begin
      tick();
      exp_v = {1'b1, 1'b0, 1'b0, 3'd0, 2'(i / 2)};
      checks++;
      if (o2 !== exp_v) begin failures++; $display("FAIL b2b_run2_%0d got=%b exp=%b", i, o2, exp_v); end
    end
    tick();
    checks++;
    if (o2 !== 8'b0_1_1_000_00) begin failures++; $display("FAIL b2b_done2 got=%b exp=%b", o2, 8'b0_1_1_000_00); end
    tick();
  endtask

  task automatic test_reset_mid_run();
    mode = M_AND; truth2 = 4'b1000; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (o2 !== 8'b1_0_0_000_10) begin failures++; $display("FAIL rst_case3 got=%b exp=%b", o2, 8'b1_0_0_000_10); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (o2 !== 8'h00) begin failures++; $display("FAIL rst_async2 got=%b exp=%b", o2, 8'h00); end
    checks++;
    if (o3 !== 8'h00) begin failures++; $display("FAIL rst_async3 got=%b exp=%b", o3, 8'h00); end
    tick();
    tick();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (o2 !== 8'h00) begin failures++; $display("FAIL rst_quiet%0d got=%b exp=%b", i, o2, 8'h00); end
    end
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (o2 !== 8'b0_1_1_000_00) begin failures++; $display("FAIL rst_rerun got=%b exp=%b", o2, 8'b0_1_1_000_00); end
    tick();
  endtask

  task automatic test_truth_change();
    mode = M_AND; truth2 = 4'b1000; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    tick();
    tick();
    truth2 = 4'b0000;
    for (int i = 2; i < 8; i++) begin
      exp_v = {1'b1, 1'b0, 1'b0, 3'd0, 2'(i / 2)};
      checks++;
      if (o2 !== exp_v) begin failures++; $display("FAIL truth_step%0d got=%b exp=%b", i, o2, exp_v); end
      tick();
    end
    checks++;
    if (o2 !== 8'b0_1_1_000_00) begin failures++; $display("FAIL truth_latched got=%b exp=%b", o2, 8'b0_1_1_000_00); end
    tick();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_and_pass();
    test_or_fail();
    test_xor_stuck();
    test_back_to_back();
    test_reset_mid_run();
    test_truth_change();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
